// File: rtl/glyph_feature_extractor.sv
// glyph_feature_extractor
// Streams a binary glyph one row per beat and accumulates two saturated
// features per frame: horizontal ink runs (edges) and diagonal 2x2
// transitions between consecutive rows (curves). The finished result is
// held on a valid/ready output until the consumer takes it.
// Optional build macro: FEAT_VERT_EDGE_EN adds vertical ink onsets
// (cur=1, prev=0) into the edge accumulator.
module glyph_feature_extractor #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_valid,
    output logic            pix_ready,
    input  logic [COLS-1:0] pix_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      edges,
    output logic [3:0]      curves,
    output logic            busy
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state_reg, state_next;
    logic            ready_en_reg;
    logic [RW-1:0]   row_cnt_reg;
    logic [COLS-1:0] prev_reg;
    logic [2:0]      edge_acc_reg;
    logic [3:0]      curve_acc_reg;
    logic [2:0]      edges_reg;
    logic [3:0]      curves_reg;

    logic            row_fire;
    logic            out_fire;
    logic            last_row;
    logic [COLS-1:0] run_bits;
    logic [COLS-1:0] diag_bits;
    logic [CW-1:0]   run_cnt;
    logic [CW-1:0]   diag_cnt;
    logic [7:0]      edge_sum;
    logic [7:0]      curve_sum;
    logic [2:0]      edge_new;
    logic [3:0]      curve_new;

    function automatic logic [CW-1:0] popcnt(input logic [COLS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < COLS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Per-pixel run starts: ink whose left neighbour is blank (or the edge).
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_run
            if (gi == 0) begin : g_first
                assign run_bits[gi] = pix_row[gi];
            end else begin : g_rest
                assign run_bits[gi] = pix_row[gi] & ~pix_row[gi-1];
            end
        end
    endgenerate

    // Per-position diagonal transitions between prev and cur; suppressed on row 0.
    generate
        for (genvar gi = 0; gi < COLS - 1; gi++) begin : g_diag
            assign diag_bits[gi] = (state_reg != IDLE) &
                ((prev_reg[gi] & ~prev_reg[gi+1] & ~pix_row[gi] & pix_row[gi+1]) |
                 (~prev_reg[gi] & prev_reg[gi+1] & pix_row[gi] & ~pix_row[gi+1]));
        end
    endgenerate
    assign diag_bits[COLS-1] = 1'b0;

    assign run_cnt  = popcnt(run_bits);
    assign diag_cnt = popcnt(diag_bits);

`ifdef FEAT_VERT_EDGE_EN
    logic [CW-1:0] vert_cnt;
    assign vert_cnt = popcnt(pix_row & ~prev_reg);
    assign edge_sum = 8'(edge_acc_reg) + 8'(run_cnt) + 8'(vert_cnt);
`else
    assign edge_sum = 8'(edge_acc_reg) + 8'(run_cnt);
`endif
    assign curve_sum = 8'(curve_acc_reg) + 8'(diag_cnt);

    // Clamp in a wide sum so the saturated value can never wrap.
    assign edge_new  = (edge_sum  > 8'd7)  ? 3'd7  : edge_sum[2:0];
    assign curve_new = (curve_sum > 8'd15) ? 4'd15 : curve_sum[3:0];

    assign pix_ready = ready_en_reg & (state_reg != DONE);
    assign row_fire  = pix_valid & pix_ready;
    assign out_valid = (state_reg == DONE);
    assign out_fire  = out_valid & out_ready;
    assign busy      = (state_reg == ACCUM);
    assign last_row  = (row_cnt_reg == RW'(ROWS - 1));
    assign edges     = edges_reg;
    assign curves    = curves_reg;

    // State register; ready is held off until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
        end
    end

    // Next-state: first row opens a frame, last row closes it, handshake frees it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (row_fire) state_next = ACCUM;
            ACCUM:   if (row_fire && last_row) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulators, previous row, row counter and the held frame result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_reg   <= '0;
            prev_reg      <= '0;
            edge_acc_reg  <= '0;
            curve_acc_reg <= '0;
            edges_reg     <= '0;
            curves_reg    <= '0;
        end else if (out_fire) begin
            row_cnt_reg   <= '0;
            prev_reg      <= '0;
            edge_acc_reg  <= '0;
            curve_acc_reg <= '0;
        end else if (row_fire) begin
            row_cnt_reg   <= row_cnt_reg + 1'b1;
            prev_reg      <= pix_row;
            edge_acc_reg  <= edge_new;
            curve_acc_reg <= curve_new;
            if (last_row) begin
                edges_reg  <= edge_new;
                curves_reg <= curve_new;
            end
        end
    end
endmodule

// File: doc/glyph_feature_extractor.md
Name: glyph_feature_extractor

Overview:
- Front end for the digit perceptron. Consumes a binary glyph bitmap one row per beat over a valid/ready stream.
- Accumulates two features per frame: an edge count (horizontal runs of ones) and a curve count (diagonal 2x2 transitions).
- Presents the saturated result as edges[2:0] / curves[3:0] with a valid/ready handshake. These widths match the classifier's feature inputs, so the outputs drive the perceptron directly.

Parameters:
- ROWS, 8, rows per frame (2..16)
- COLS, 8, pixels per row (2..16); pixel j = pix_row[j], j=0 leftmost

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- pix_valid  input  1  pix_row holds a valid row
- pix_ready  output  1  block accepts a row this cycle
- pix_row  input  COLS  one glyph row, 1 = ink
- out_valid  output  1  edges/curves hold a completed frame result
- out_ready  input  1  downstream accepts result
- edges  output  3  saturated edge count
- curves  output  4  saturated curve count
- busy  output  1  at least one row of the current frame accepted, result not yet presented

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, row counter=0, prev-row register=0, accumulators=0
  - out_valid=0, edges=0, curves=0, busy=0; pix_ready=1 from the first clock after release
- States: IDLE (no rows yet), ACCUM (1..ROWS-1 rows taken), DONE (result held).
- pix_ready=1 in IDLE/ACCUM, 0 in DONE. A row transfers on pix_valid & pix_ready.
- Per accepted row, with cur=pix_row and prev=previously accepted row (all zeros for row 0):
  - run term = count of j where cur[j]=1 and (j==0 or cur[j-1]=0)
  - diag term = count of j in 0..COLS-2 where (prev[j]&~prev[j+1]&~cur[j]&cur[j+1]) or (~prev[j]&prev[j+1]&cur[j]&~cur[j+1]); forced to 0 for row 0
  - edge acc += run term, saturating at 7; curve acc += diag term, saturating at 15; prev <= cur; row counter += 1
- Row transitions:
  - First row: IDLE -> ACCUM.
  - Row ROWS-1 accepted: DONE next cycle. edges/curves are loaded with the final accumulators, out_valid=1.
  - Latency: 1 cycle from the last-row handshake to out_valid.
- In DONE:
  - edges/curves/out_valid are held stable until out_ready=1.
  - On handshake, next cycle: out_valid=0, state=IDLE, accumulators/prev/counter cleared, pix_ready=1.
  - edges/curves keep their last value after handshake.
- Minimum frame period is ROWS+1 cycles. No row is ever accepted while in DONE.
- pix_valid low mid-frame: stall, no state change, no timeout.
- Reset mid-frame aborts the frame. No partial result is ever presented.
- Accumulators are internally ≥ 3+1 / 4+1 bits or clamp-compare; the saturated value never wraps.

Optional Feature:
- Macro: FEAT_VERT_EDGE_EN
- Defined: each accepted row also adds vert term = count of j where cur[j]=1 and prev[j]=0 into the edge accumulator (same saturation at 7). Row 0 compares against zeros.
- Undefined: edges = runs only. No extra logic is present.

Test Plan:
- All-zero frame (8 rows 0x00), out_ready=1 -> out_valid 1 cycle after row 7; edges=0, curves=0.
- Row0=0x55, rows1..7=0x00 -> edges=4, curves=0. With FEAT_VERT_EDGE_EN: edges=7 (4+4 saturated).
- Diagonal frame row r = 1<<r -> edges=7 (8 runs, saturated), curves=7.
- Checker frame alternating 0xAA/0x55 -> edges=7 (32 saturated), curves=15 (49 saturated).
- Backpressure: diagonal frame, out_ready=0 for 5 cycles with pix_valid held high:
  - out_valid, edges=7, curves=7 stable; pix_ready=0; no row consumed
  - then out_ready=1 -> next cycle pix_ready=1; the following all-zero frame yields 0/0.
- Reset after 3 rows of checker frame -> out_valid=0, busy=0, edges=0, curves=0 immediately; the following Row0=0x55 frame yields edges=4, curves=0 (no carryover).
